// File: rtl/exec_step_controller.sv
// Debug run/step controller: gates the pipeline enable from byte commands and reports PC/cycle status on stop, step or halt.
// Latency: an accepted CONT/STEP raises o_enable next cycle; the status record is valid the cycle after the last enabled cycle.
// Backpressure: o_cmd_ready low in STEP/REPORT; REPORT holds until i_report_ready. Optional EXEC_RUN_LIMIT_EN adds RUN_LIMIT/o_timeout.
module exec_step_controller #(
    parameter int          PC_WIDTH  = 32,
    parameter int          CNT_WIDTH = 32,
    parameter logic [7:0]  CMD_CONT  = 8'h43,
    parameter logic [7:0]  CMD_STEP  = 8'h53,
    parameter logic [7:0]  CMD_STOP  = 8'h50
`ifdef EXEC_RUN_LIMIT_EN
    ,
    parameter int          RUN_LIMIT = 1024
`endif
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic [7:0]           i_cmd,
    input  logic                 i_cmd_valid,
    output logic                 o_cmd_ready,
    input  logic                 i_halt,
    input  logic [PC_WIDTH-1:0]  i_pc,
    output logic                 o_enable,
    output logic                 o_report_valid,
    input  logic                 i_report_ready,
    output logic [PC_WIDTH-1:0]  o_pc_snapshot,
    output logic [CNT_WIDTH-1:0] o_cycle_count,
    output logic                 o_halted,
`ifdef EXEC_RUN_LIMIT_EN
    output logic                 o_timeout,
`endif
    output logic [2:0]           o_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RUN    = 3'd1,
        S_STEP   = 3'd2,
        S_REPORT = 3'd3,
        S_HALTED = 3'd4
    } state_t;

    state_t state, state_nxt;
    logic   cmd_acc;
    logic   capture;
    logic   halt_flag;

    assign o_enable       = (state == S_RUN) || (state == S_STEP);
    assign o_report_valid = (state == S_REPORT);
    assign o_cmd_ready    = (state == S_IDLE) || (state == S_RUN) || (state == S_HALTED);
    assign o_state        = state;
    assign cmd_acc        = i_cmd_valid && o_cmd_ready;

`ifdef EXEC_RUN_LIMIT_EN
    logic [31:0] run_cnt;
    logic        limit_hit;
    logic        timeout_set;

    // Counts enabled cycles of the current run; the RUN_LIMIT-th cycle is the last one.
    assign limit_hit = (state == S_RUN) && (run_cnt == 32'(RUN_LIMIT - 1));
`endif

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        halt_flag = 1'b0;
`ifdef EXEC_RUN_LIMIT_EN
        timeout_set = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                if (cmd_acc && i_cmd == CMD_CONT) begin
                    state_nxt = S_RUN;
                end else if (cmd_acc && i_cmd == CMD_STEP) begin
                    state_nxt = S_STEP;
                end
            end
            S_RUN: begin
                if (i_halt) begin
                    state_nxt = S_REPORT;
                    capture   = 1'b1;
                    halt_flag = 1'b1;
                end else if (cmd_acc && i_cmd == CMD_STOP) begin
                    state_nxt = S_REPORT;
                    capture   = 1'b1;
`ifdef EXEC_RUN_LIMIT_EN
                end else if (limit_hit) begin
                    state_nxt   = S_REPORT;
                    capture     = 1'b1;
                    timeout_set = 1'b1;
`endif
                end
            end
            S_STEP: begin
                state_nxt = S_REPORT;
                capture   = 1'b1;
                halt_flag = i_halt;
            end
            S_REPORT: begin
                if (i_report_ready) begin
                    state_nxt = o_halted ? S_HALTED : S_IDLE;
                end
            end
            S_HALTED: state_nxt = S_HALTED;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            state         <= S_IDLE;
            o_cycle_count <= '0;
            o_pc_snapshot <= '0;
            o_halted      <= 1'b0;
        end else begin
            state <= state_nxt;
            if (o_enable && (o_cycle_count != '1)) begin
                o_cycle_count <= o_cycle_count + 1'b1;
            end
            if (capture) begin
                o_pc_snapshot <= i_pc;
                o_halted      <= halt_flag;
            end
        end
    end

`ifdef EXEC_RUN_LIMIT_EN
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            run_cnt   <= '0;
            o_timeout <= 1'b0;
        end else begin
            if (state != S_RUN) begin
                run_cnt <= '0;
            end else begin
                run_cnt <= run_cnt + 1'b1;
            end
            if (timeout_set) begin
                o_timeout <= 1'b1;
            end else if (state == S_IDLE && cmd_acc && (i_cmd == CMD_CONT || i_cmd == CMD_STEP)) begin
                o_timeout <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_exec_step_controller.sv
// Self-checking bench for exec_step_controller: randomized run/step/halt scenarios against a cycle-count and status model.
module tb_exec_step_controller;
    localparam int PW = 32;
    localparam int CW = 8;
    localparam int CMAX = 255;
    localparam logic [7:0] C_CONT = 8'h43;
    localparam logic [7:0] C_STEP = 8'h53;
    localparam logic [7:0] C_STOP = 8'h50;

    logic          i_clock = 1'b0;
    logic          i_reset = 1'b0;
    logic [7:0]    i_cmd = 8'h00;
    logic          i_cmd_valid = 1'b0;
    logic          o_cmd_ready;
    logic          i_halt = 1'b0;
    logic [PW-1:0] i_pc = '0;
    logic          o_enable;
    logic          o_report_valid;
    logic          i_report_ready = 1'b0;
    logic [PW-1:0] o_pc_snapshot;
    logic [CW-1:0] o_cycle_count;
    logic          o_halted;
    logic [2:0]    o_state;
`ifdef EXEC_RUN_LIMIT_EN
    logic          o_timeout;
`endif

    int checks = 0;
    int failures = 0;
    int exp_raw = 0;

    exec_step_controller #(
        .PC_WIDTH (PW),
        .CNT_WIDTH(CW)
`ifdef EXEC_RUN_LIMIT_EN
        ,
        .RUN_LIMIT(16)
`endif
    ) dut (
        .i_clock       (i_clock),
        .i_reset       (i_reset),
        .i_cmd         (i_cmd),
        .i_cmd_valid   (i_cmd_valid),
        .o_cmd_ready   (o_cmd_ready),
        .i_halt        (i_halt),
        .i_pc          (i_pc),
        .o_enable      (o_enable),
        .o_report_valid(o_report_valid),
        .i_report_ready(i_report_ready),
        .o_pc_snapshot (o_pc_snapshot),
        .o_cycle_count (o_cycle_count),
        .o_halted      (o_halted),
`ifdef EXEC_RUN_LIMIT_EN
        .o_timeout     (o_timeout),
`endif
        .o_state       (o_state)
    );

    always #5 i_clock = ~i_clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic int exp_cnt();
        return (exp_raw > CMAX) ? CMAX : exp_raw;
    endfunction

    function automatic logic [7:0] junk_byte();
        logic [7:0] b;
        b = 8'($urandom);
        while (b == C_CONT || b == C_STEP || b == C_STOP) b = 8'($urandom);
        return b;
    endfunction

    task automatic tick;
        @(posedge i_clock);
        #1;
    endtask

    task automatic do_reset;
        i_reset = 1'b0; i_cmd_valid = 1'b0; i_halt = 1'b0; i_report_ready = 1'b0;
        tick; tick;
        i_reset = 1'b1;
        exp_raw = 0;
    endtask

    task automatic send_cmd(input logic [7:0] c);
        i_cmd = c; i_cmd_valid = 1'b1;
        tick;
        i_cmd_valid = 1'b0;
    endtask

    task automatic accept_report;
        i_report_ready = 1'b1;
        tick;
        i_report_ready = 1'b0;
    endtask

    task automatic test_reset;
        do_reset;
        checks++; if (o_state !== 3'd0) begin failures++; $display("FAIL reset_state: got %0d want 0", o_state); end
        checks++; if ({o_enable, o_report_valid, o_halted} !== 3'b000) begin failures++; $display("FAIL reset_flags: got %b want 000", {o_enable, o_report_valid, o_halted}); end
        checks++; if (o_cycle_count !== 8'd0 || o_pc_snapshot !== 32'd0) begin failures++; $display("FAIL reset_data: cnt %0d pc %h want 0 0", o_cycle_count, o_pc_snapshot); end
        checks++; if (o_cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b want 1", o_cmd_ready); end
        // reset on the fifth enabled cycle of a run
        send_cmd(C_CONT);
        repeat (4) tick;
        checks++; if (o_enable !== 1'b1 || o_cycle_count !== 8'd4) begin failures++; $display("FAIL run_before_reset: en %b cnt %0d want 1 4", o_enable, o_cycle_count); end
        i_reset = 1'b0; tick; i_reset = 1'b1;
        checks++; if (o_state !== 3'd0 || o_enable !== 1'b0 || o_cycle_count !== 8'd0) begin failures++; $display("FAIL reset_mid_run: st %0d en %b cnt %0d want 0 0 0", o_state, o_enable, o_cycle_count); end
        // reset while a report is pending
        i_pc = 32'hABCD0000;
        send_cmd(C_STEP); tick;
        i_reset = 1'b0; tick; i_reset = 1'b1;
        checks++; if (o_report_valid !== 1'b0 || o_pc_snapshot !== 32'd0 || o_cycle_count !== 8'd0) begin failures++; $display("FAIL reset_mid_report: rv %b pc %h cnt %0d want 0 0 0", o_report_valid, o_pc_snapshot, o_cycle_count); end
        exp_raw = 0;
    endtask

    task automatic test_step;
        logic [PW-1:0] pc;
        do_reset;
        for (int k = 0; k < 6; k++) begin
            pc = (k == 0) ? 32'h00000010 : $urandom;
            i_pc = (k == 0) ? pc : $urandom;
            send_cmd(C_STEP);
            checks++; if (o_enable !== 1'b1 || o_state !== 3'd2 || o_cmd_ready !== 1'b0) begin failures++; $display("FAIL step_active: en %b st %0d rdy %b want 1 2 0", o_enable, o_state, o_cmd_ready); end
            i_pc = pc;
            tick;
            exp_raw++;
            i_pc = $urandom;
            checks++; if (o_enable !== 1'b0 || o_report_valid !== 1'b1) begin failures++; $display("FAIL step_len: en %b rv %b want 0 1", o_enable, o_report_valid); end
            checks++; if (o_pc_snapshot !== pc || o_cycle_count !== 8'(exp_cnt()) || o_halted !== 1'b0) begin failures++; $display("FAIL step_report: pc %h cnt %0d h %b want %h %0d 0", o_pc_snapshot, o_cycle_count, o_halted, pc, exp_cnt()); end
            repeat ($urandom_range(0, 3)) tick;
            accept_report;
            checks++; if (o_state !== 3'd0) begin failures++; $display("FAIL step_done: st %0d want 0", o_state); end
        end
    endtask

    // One CONT..STOP run of n enabled cycles with random PC and junk commands.
    task automatic run_stop(input int n, input bit hold3);
        logic [PW-1:0] pc;
        send_cmd(C_CONT);
        for (int c = 1; c < n; c++) begin
            i_pc = $urandom; i_cmd = junk_byte(); i_cmd_valid = 1'($urandom);
            tick;
        end
        pc = $urandom; i_pc = pc; i_cmd = C_STOP; i_cmd_valid = 1'b1;
        tick;
        i_cmd_valid = 1'b0;
        exp_raw += n;
        checks++; if (o_state !== 3'd3 || o_pc_snapshot !== pc || o_cycle_count !== 8'(exp_cnt()) || o_halted !== 1'b0) begin failures++; $display("FAIL stop_report n=%0d: st %0d pc %h cnt %0d h %b want 3 %h %0d 0", n, o_state, o_pc_snapshot, o_cycle_count, o_halted, pc, exp_cnt()); end
        if (hold3) begin
            for (int w = 0; w < 3; w++) begin
                i_pc = $urandom;
                tick;
                checks++; if (o_report_valid !== 1'b1 || o_enable !== 1'b0 || o_pc_snapshot !== pc || o_cycle_count !== 8'(exp_cnt())) begin failures++; $display("FAIL report_hold w=%0d: rv %b en %b pc %h cnt %0d", w, o_report_valid, o_enable, o_pc_snapshot, o_cycle_count); end
            end
        end
        accept_report;
        checks++; if (o_state !== 3'd0) begin failures++; $display("FAIL stop_done: st %0d want 0", o_state); end
    endtask

    task automatic test_run_stop;
        do_reset;
        run_stop(8, 1'b1);
        for (int k = 0; k < 4; k++) run_stop($urandom_range(1, 15), 1'b1);
    endtask

    task automatic test_halt;
        do_reset;
        i_halt = 1'b1; tick; tick; i_halt = 1'b0;
        checks++; if (o_state !== 3'd0) begin failures++; $display("FAIL halt_idle_ignored: st %0d want 0", o_state); end
        send_cmd(C_CONT);
        repeat (3) tick;
        i_pc = 32'h2C; i_halt = 1'b1; i_cmd = C_STOP; i_cmd_valid = 1'b1;
        tick;
        i_halt = 1'b0; i_cmd_valid = 1'b0;
        checks++; if (o_state !== 3'd3 || o_halted !== 1'b1 || o_pc_snapshot !== 32'h2C || o_cycle_count !== 8'd4) begin failures++; $display("FAIL halt_report: st %0d h %b pc %h cnt %0d want 3 1 2c 4", o_state, o_halted, o_pc_snapshot, o_cycle_count); end
        accept_report;
        checks++; if (o_state !== 3'd4 || o_cmd_ready !== 1'b1) begin failures++; $display("FAIL halted_state: st %0d rdy %b want 4 1", o_state, o_cmd_ready); end
        send_cmd(C_CONT);
        i_halt = 1'($urandom);
        repeat (3) tick;
        i_halt = 1'b0;
        checks++; if (o_state !== 3'd4 || o_enable !== 1'b0 || o_cycle_count !== 8'd4) begin failures++; $display("FAIL halted_sticky: st %0d en %b cnt %0d want 4 0 4", o_state, o_enable, o_cycle_count); end
        // halt retiring in a single step
        do_reset;
        i_pc = 32'h77;
        send_cmd(C_STEP);
        i_halt = 1'b1; tick; i_halt = 1'b0;
        checks++; if (o_halted !== 1'b1 || o_pc_snapshot !== 32'h77 || o_cycle_count !== 8'd1) begin failures++; $display("FAIL step_halt: h %b pc %h cnt %0d want 1 77 1", o_halted, o_pc_snapshot, o_cycle_count); end
        accept_report;
        checks++; if (o_state !== 3'd4) begin failures++; $display("FAIL step_halted_state: st %0d want 4", o_state); end
    endtask

    task automatic test_gating;
        do_reset;
        i_pc = 32'h5;
        send_cmd(C_STEP); tick;
        i_cmd = C_STEP; i_cmd_valid = 1'b1;
        checks++; if (o_cmd_ready !== 1'b0) begin failures++; $display("FAIL gate_report_ready: got %b want 0", o_cmd_ready); end
        repeat (2) tick;
        checks++; if (o_state !== 3'd3 || o_cycle_count !== 8'd1 || o_enable !== 1'b0) begin failures++; $display("FAIL gate_report_hold: st %0d cnt %0d en %b want 3 1 0", o_state, o_cycle_count, o_enable); end
        i_cmd_valid = 1'b0;
        accept_report;
        i_cmd = 8'h41; i_cmd_valid = 1'b1;
        checks++; if (o_cmd_ready !== 1'b1) begin failures++; $display("FAIL gate_idle_ready: got %b want 1", o_cmd_ready); end
        tick;
        i_cmd_valid = 1'b0;
        checks++; if (o_state !== 3'd0 || o_enable !== 1'b0 || o_cycle_count !== 8'd1) begin failures++; $display("FAIL gate_junk: st %0d en %b cnt %0d want 0 0 1", o_state, o_enable, o_cycle_count); end
    endtask

`ifdef EXEC_RUN_LIMIT_EN
    task automatic test_run_limit;
        int n;
        do_reset;
        send_cmd(C_CONT);
        n = 0;
        for (int b = 0; b < 100 && o_enable === 1'b1; b++) begin
            n++;
            tick;
        end
        checks++; if (n != 16) begin failures++; $display("FAIL limit_cycles: got %0d want 16", n); end
        checks++; if (o_state !== 3'd3 || o_timeout !== 1'b1 || o_halted !== 1'b0 || o_cycle_count !== 8'd16) begin failures++; $display("FAIL limit_report: st %0d to %b h %b cnt %0d want 3 1 0 16", o_state, o_timeout, o_halted, o_cycle_count); end
        accept_report;
        checks++; if (o_state !== 3'd0 || o_timeout !== 1'b1) begin failures++; $display("FAIL limit_idle: st %0d to %b want 0 1", o_state, o_timeout); end
        send_cmd(C_STEP);
        checks++; if (o_timeout !== 1'b0) begin failures++; $display("FAIL limit_clear: to %b want 0", o_timeout); end
    endtask
`else
    task automatic test_no_limit;
        do_reset;
        send_cmd(C_CONT);
        repeat (39) begin i_pc = $urandom; tick; end
        checks++; if (o_enable !== 1'b1 || o_cycle_count !== 8'd39) begin failures++; $display("FAIL long_run: en %b cnt %0d want 1 39", o_enable, o_cycle_count); end
        i_cmd = C_STOP; i_cmd_valid = 1'b1; tick; i_cmd_valid = 1'b0;
        accept_report;
    endtask
`endif

    task automatic test_saturation;
        do_reset;
        while (exp_raw < 270) run_stop($urandom_range(5, 15), 1'b0);
        checks++; if (o_cycle_count !== 8'd255) begin failures++; $display("FAIL saturate: got %0d want 255", o_cycle_count); end
        send_cmd(C_STEP); tick;
        checks++; if (o_cycle_count !== 8'd255) begin failures++; $display("FAIL saturate_step: got %0d want 255", o_cycle_count); end
        accept_report;
    endtask

    initial begin
        test_reset;
        test_step;
        test_run_stop;
        test_halt;
        test_gating;
`ifdef EXEC_RUN_LIMIT_EN
        test_run_limit;
`else
        test_no_limit;
`endif
        test_saturation;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/exec_step_controller.md
Name: exec_step_controller

Overview:
- Debug-side execution controller that produces the pipeline-wide enable consumed by the program counter's i_enable input and by the other pipeline stages.
- Accepts byte commands from the debug command path, such as the UART receiver, using a valid/ready handshake.
- Runs the pipeline either continuously or for exactly one clock.
- On stop, step or pipeline halt, it presents a status record (PC snapshot, cycle count, halted flag) to the debug transmitter via a valid/ready handshake.

Parameters:
- PC_WIDTH, 32, width of the sampled PC and of o_pc_snapshot.
- CNT_WIDTH, 32, width of the enabled-cycle counter.
- CMD_CONT, 8'h43, command byte that starts continuous run.
- CMD_STEP, 8'h53, command byte that executes a single cycle.
- CMD_STOP, 8'h50, command byte that stops a continuous run.

Ports:
- i_clock  in  1  system clock, rising edge
- i_reset  in  1  synchronous, active-low reset
- i_cmd  in  8  command byte
- i_cmd_valid  in  1  command byte valid
- o_cmd_ready  out  1  controller accepts the command this cycle
- i_halt  in  1  halt instruction retired (from WB); meaningful only while o_enable=1
- i_pc  in  PC_WIDTH  current PC (program counter o_pc)
- o_enable  out  1  pipeline enable, drives PC i_enable
- o_report_valid  out  1  status record valid
- i_report_ready  in  1  status consumer ready
- o_pc_snapshot  out  PC_WIDTH  PC captured at stop
- o_cycle_count  out  CNT_WIDTH  total enabled cycles since reset
- o_halted  out  1  status record is from a halt
- o_state  out  3  encoded FSM state, for debug

Behaviour:
- Reset (i_reset=0 at a rising edge):
  - State becomes IDLE.
  - o_enable, o_report_valid, o_halted, o_pc_snapshot and o_cycle_count all become 0.
  - Reset takes priority over everything, including mid-RUN and mid-REPORT; any pending report is discarded.
- States and encodings: IDLE=0, RUN=1, STEP=2, REPORT=3, HALTED=4.
- Handshakes:
  - A command is accepted on a rising edge where i_cmd_valid=1 and o_cmd_ready=1.
  - A report is accepted on a rising edge where o_report_valid=1 and i_report_ready=1.
- Outputs decoded from state:
  - o_enable=1 exactly when state is RUN or STEP.
  - o_report_valid=1 exactly when state is REPORT.
- o_cmd_ready: 1 in IDLE, RUN and HALTED; 0 in STEP and REPORT.
- IDLE:
  - CMD_CONT goes to RUN.
  - CMD_STEP goes to STEP.
  - Any other byte is consumed and ignored; state stays IDLE.
- RUN:
  - o_cycle_count increments on every edge in RUN.
  - If i_halt=1, go to REPORT with halted flag set. Halt takes priority over a simultaneous CMD_STOP.
  - Else if CMD_STOP is accepted, go to REPORT with halted flag cleared.
  - Other bytes are consumed and ignored.
- STEP:
  - Lasts exactly one cycle (one enabled clock), then goes to REPORT.
  - o_cycle_count increments by 1.
  - The halted flag is set from i_halt in that cycle.
- Capture on the edge leaving RUN or STEP:
  - o_pc_snapshot <= i_pc, i.e. the value present in the last enabled cycle.
  - o_halted <= the halted flag.
  - o_pc_snapshot and o_halted hold their values until the next capture.
- REPORT:
  - Holds o_report_valid=1 with stable data until the report is accepted.
  - On acceptance, goes to HALTED if o_halted=1, else to IDLE.
  - Can wait indefinitely; o_enable stays 0 throughout.
- HALTED:
  - o_enable=0.
  - All commands are consumed and ignored.
  - Exit only by reset.
- Counter arithmetic: unsigned, saturating at all-ones; no wrap-around.
- Latency: an accepted CMD_CONT or CMD_STEP raises o_enable on the next cycle.
- i_halt is ignored in IDLE, REPORT and HALTED.

Optional Feature:
- Macro: EXEC_RUN_LIMIT_EN.
- When defined:
  - Adds parameter RUN_LIMIT (default 1024).
  - Adds a per-run counter that clears on entry to RUN.
  - If RUN reaches RUN_LIMIT enabled cycles without a halt or stop, the controller goes to REPORT with o_halted=0.
  - Adds output o_timeout (1 bit). It is set on that transition, cleared on the next accepted CMD_CONT or CMD_STEP, and 0 at reset.
- When not defined: there is no limit, no o_timeout port, and RUN lasts until a halt or stop.

Test Plan:
- Reset mid-operation:
  - Stimulus: after reset, send CMD_CONT; hold i_reset=0 for 1 cycle on the 5th enabled cycle.
  - Required response: state IDLE, o_enable=0, o_cycle_count=0 on the next cycle.
- Single step:
  - Stimulus: send CMD_STEP with i_pc=0x00000010.
  - Required response: o_enable high for exactly 1 cycle; then o_report_valid=1 with o_pc_snapshot=0x10, o_cycle_count=1, o_halted=0; after the report is accepted, state IDLE.
- Continuous run then stop:
  - Stimulus: CMD_CONT, then CMD_STOP accepted after 7 enabled cycles; keep i_report_ready=0 for 3 cycles.
  - Required response: o_cycle_count=8; report held stable for all 3 wait cycles, then accepted.
- Halt during run:
  - Stimulus: CMD_CONT; assert i_halt together with CMD_STOP on enabled cycle 4, i_pc=0x2C.
  - Required response: o_halted=1, o_pc_snapshot=0x2C; after acceptance, state HALTED; a following CMD_CONT is ignored and o_enable stays 0.
- Command gating:
  - Stimulus: present CMD_STEP while in REPORT; present byte 0x41 in IDLE.
  - Required response: CMD_STEP is not accepted (o_cmd_ready=0); 0x41 is consumed with no state change.
- Run limit (build with EXEC_RUN_LIMIT_EN, RUN_LIMIT=16):
  - Stimulus: CMD_CONT with no halt and no stop.
  - Required response: exactly 16 enabled cycles; report with o_timeout=1, o_halted=0.
